// File: rtl/hazard_stall_ctrl.sv
// ID-stage hazard detection and branch-operand forwarding for a 5-stage MIPS pipeline.
// Stalls are held for a counted number of cycles so multi-cycle loads are covered.
module hazard_stall_ctrl #(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 0,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_branch,
    input  logic              id_flush,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_regwrite,
    input  logic              ex_memread,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_regwrite,
    input  logic              mem_memread,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_regwrite,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              idex_bubble,
    output logic [1:0]        fwd_rs,
    output logic [1:0]        fwd_rt,
    output logic              stall_active,
    output logic [CNT_W-1:0]  stall_cycles
);

    // Wide enough for the longest stall (branch behind a load with LOAD_LAT=3 -> 5 cycles).
    localparam int REM_W = 3;

    localparam logic [REM_W-1:0] ZERO_N        = {REM_W{1'b0}};
    localparam logic [REM_W-1:0] ONE_N         = {{(REM_W-1){1'b0}}, 1'b1};
    localparam logic [REM_W-1:0] N_LOAD_USE    = REM_W'(1 + LOAD_LAT);
    localparam logic [REM_W-1:0] N_BR_EX_ALU   = ONE_N;
    localparam logic [REM_W-1:0] N_BR_EX_LOAD  = REM_W'(2 + LOAD_LAT);
    localparam logic [REM_W-1:0] N_BR_MEM_LOAD = REM_W'(1 + LOAD_LAT);
    localparam logic [REG_AW-1:0] REG_ZERO     = {REG_AW{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_MAX      = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [REM_W-1:0]   rem_r;
    logic [REM_W-1:0]   rem_nxt_s;
    logic [CNT_W-1:0]   stall_cycles_r;

    logic               match_ex_s;
    logic               match_mem_s;
    logic [REM_W-1:0]   term_lu_s;
    logic [REM_W-1:0]   term_br_alu_s;
    logic [REM_W-1:0]   term_br_exld_s;
    logic [REM_W-1:0]   term_br_memld_s;
    logic [REM_W-1:0]   need_s;
    logic               hazard_req_s;
    logic               stall_s;
    logic [1:0]         fwd_rs_s;
    logic [1:0]         fwd_rt_s;

    function automatic logic reg_match(
        input logic [REG_AW-1:0] rd,
        input logic [REG_AW-1:0] r,
        input logic              use_r
    );
        return (rd == r) && (rd != REG_ZERO) && use_r;
    endfunction

    function automatic logic [REM_W-1:0] max_n(
        input logic [REM_W-1:0] a,
        input logic [REM_W-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    // EX/MEM ALU results are preferred over MEM/WB; loads still in MEM cannot forward yet.
    function automatic logic [1:0] fwd_select(input logic [REG_AW-1:0] r);
        logic [1:0] sel;
        sel = 2'b00;
        if (mem_regwrite && !mem_memread && (mem_rd == r) && (mem_rd != REG_ZERO)) begin
            sel = 2'b10;
        end else if (wb_regwrite && (wb_rd == r) && (wb_rd != REG_ZERO)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Hazard classification: required stall length is the worst case over all matches.
    always_comb begin
        match_ex_s  = id_valid && (reg_match(ex_rd, id_rs, id_use_rs) ||
                                   reg_match(ex_rd, id_rt, id_use_rt));
        match_mem_s = id_valid && (reg_match(mem_rd, id_rs, id_use_rs) ||
                                   reg_match(mem_rd, id_rt, id_use_rt));

        term_lu_s       = (ex_memread && match_ex_s) ? N_LOAD_USE : ZERO_N;
        term_br_alu_s   = (id_branch && ex_regwrite && !ex_memread && match_ex_s) ?
                          N_BR_EX_ALU : ZERO_N;
        term_br_exld_s  = (id_branch && ex_memread && match_ex_s) ? N_BR_EX_LOAD : ZERO_N;
        term_br_memld_s = (id_branch && mem_memread && match_mem_s) ? N_BR_MEM_LOAD : ZERO_N;

        need_s       = max_n(max_n(term_lu_s, term_br_alu_s),
                             max_n(term_br_exld_s, term_br_memld_s));
        hazard_req_s = (need_s != ZERO_N);
    end

    // Stall FSM next-state and stall decision; a flush overrides any pending stall.
    always_comb begin
        state_nxt_s = state_r;
        rem_nxt_s   = rem_r;
        stall_s     = 1'b0;
        if (id_flush) begin
            stall_s     = 1'b0;
            state_nxt_s = ST_IDLE;
            rem_nxt_s   = ZERO_N;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (hazard_req_s) begin
                        stall_s = 1'b1;
                        if (need_s > ONE_N) begin
                            state_nxt_s = ST_STALL;
                            rem_nxt_s   = need_s - ONE_N;
                        end else begin
                            state_nxt_s = ST_IDLE;
                            rem_nxt_s   = ZERO_N;
                        end
                    end else begin
                        stall_s     = 1'b0;
                        state_nxt_s = ST_IDLE;
                        rem_nxt_s   = ZERO_N;
                    end
                end
                ST_STALL: begin
                    stall_s = 1'b1;
                    if (rem_r <= ONE_N) begin
                        state_nxt_s = ST_IDLE;
                        rem_nxt_s   = ZERO_N;
                    end else begin
                        state_nxt_s = ST_STALL;
                        rem_nxt_s   = rem_r - ONE_N;
                    end
                end
                default: begin
                    stall_s     = 1'b0;
                    state_nxt_s = ST_IDLE;
                    rem_nxt_s   = ZERO_N;
                end
            endcase
        end
    end

    // Forwarding select for both branch operands.
    always_comb begin
        fwd_rs_s = fwd_select(id_rs);
        fwd_rt_s = fwd_select(id_rt);
    end

    // FSM state and remaining-stall counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            rem_r   <= ZERO_N;
        end else begin
            state_r <= state_nxt_s;
            rem_r   <= rem_nxt_s;
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_r <= {CNT_W{1'b0}};
        end else if (stall_s && (stall_cycles_r != CNT_MAX)) begin
            stall_cycles_r <= stall_cycles_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cycles_r <= stall_cycles_r;
        end
    end

    // Output drive; reset forces the pipeline-open values even while hazard inputs are live.
    always_comb begin
        if (!rst_n) begin
            pc_write     = 1'b1;
            ifid_write   = 1'b1;
            idex_bubble  = 1'b0;
            fwd_rs       = 2'b00;
            fwd_rt       = 2'b00;
            stall_active = 1'b0;
        end else begin
            pc_write     = !stall_s;
            ifid_write   = !stall_s;
            idex_bubble  = stall_s;
            fwd_rs       = fwd_rs_s;
            fwd_rt       = fwd_rt_s;
            stall_active = (state_r == ST_STALL);
        end
    end

    assign stall_cycles = stall_cycles_r;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: four instances (LOAD_LAT 0/2/3 and a narrow counter) share stimulus.
// Table-driven single-cycle vectors plus hand-written multi-cycle stall, flush and reset sequences.
module tb_hazard_stall_ctrl;

    logic       clk;
    logic       rst_n;
    logic       id_valid, id_use_rs, id_use_rt, id_branch, id_flush;
    logic [4:0] id_rs, id_rt, ex_rd, mem_rd, wb_rd;
    logic       ex_regwrite, ex_memread, mem_regwrite, mem_memread, wb_regwrite;

    logic       pc_w   [4];
    logic       ifid_w [4];
    logic       bub    [4];
    logic       sa     [4];
    logic [1:0] frs    [4];
    logic [1:0] frt    [4];
    logic [15:0] sc0, sc2, sc3;
    logic [1:0]  sc_sat;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic v; logic [4:0] rs; logic [4:0] rt; logic urs; logic urt; logic br; logic fl;
        logic [4:0] exrd; logic exrw; logic exmr;
        logic [4:0] memrd; logic memrw; logic memmr;
        logic [4:0] wbrd; logic wbrw;
    } in_t;

    typedef struct {
        in_t        vin;
        logic       st;
        logic [1:0] fr;
        logic [1:0] ft;
    } vec_t;

    typedef struct {
        int         inst;
        logic [7:0] exp;
        string      name;
    } sb_t;

    vec_t tbl [$];
    sb_t  sbq [$];

    hazard_stall_ctrl #(.REG_AW(5), .LOAD_LAT(0), .CNT_W(16)) u0 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_branch(id_branch), .id_flush(id_flush),
        .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_memread(mem_memread),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
        .pc_write(pc_w[0]), .ifid_write(ifid_w[0]), .idex_bubble(bub[0]),
        .fwd_rs(frs[0]), .fwd_rt(frt[0]), .stall_active(sa[0]), .stall_cycles(sc0));

    hazard_stall_ctrl #(.REG_AW(5), .LOAD_LAT(2), .CNT_W(16)) u2 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_branch(id_branch), .id_flush(id_flush),
        .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_memread(mem_memread),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
        .pc_write(pc_w[1]), .ifid_write(ifid_w[1]), .idex_bubble(bub[1]),
        .fwd_rs(frs[1]), .fwd_rt(frt[1]), .stall_active(sa[1]), .stall_cycles(sc2));

    hazard_stall_ctrl #(.REG_AW(5), .LOAD_LAT(3), .CNT_W(16)) u3 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_branch(id_branch), .id_flush(id_flush),
        .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_memread(mem_memread),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
        .pc_write(pc_w[2]), .ifid_write(ifid_w[2]), .idex_bubble(bub[2]),
        .fwd_rs(frs[2]), .fwd_rt(frt[2]), .stall_active(sa[2]), .stall_cycles(sc3));

    hazard_stall_ctrl #(.REG_AW(5), .LOAD_LAT(0), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_branch(id_branch), .id_flush(id_flush),
        .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_memread(mem_memread),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
        .pc_write(pc_w[3]), .ifid_write(ifid_w[3]), .idex_bubble(bub[3]),
        .fwd_rs(frs[3]), .fwd_rt(frt[3]), .stall_active(sa[3]), .stall_cycles(sc_sat));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] out_of(input int i);
        return {pc_w[i], ifid_w[i], bub[i], sa[i], frs[i], frt[i]};
    endfunction

    function automatic logic [7:0] exp_pack(input logic st, input logic act,
                                            input logic [1:0] fr, input logic [1:0] ft);
        return {~st, ~st, st, act, fr, ft};
    endfunction

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual={pc,ifid,bub,sa,frs,frt}=%b required=%b", name, act, exp);
        end
    endtask

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic drive(input in_t v);
        id_valid = v.v; id_rs = v.rs; id_rt = v.rt; id_use_rs = v.urs; id_use_rt = v.urt;
        id_branch = v.br; id_flush = v.fl;
        ex_rd = v.exrd; ex_regwrite = v.exrw; ex_memread = v.exmr;
        mem_rd = v.memrd; mem_regwrite = v.memrw; mem_memread = v.memmr;
        wb_rd = v.wbrd; wb_regwrite = v.wbrw;
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare on the falling edge.
    task automatic step(input string name, input int inst, input in_t v, input logic st,
                        input logic act, input logic [1:0] fr, input logic [1:0] ft);
        sb_t e;
        drive(v);
        e.inst = inst;
        e.exp  = exp_pack(st, act, fr, ft);
        e.name = name;
        sbq.push_back(e);
        @(negedge clk);
        e = sbq.pop_front();
        check8(e.name, out_of(e.inst), e.exp);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_t z;
        z = '0;
        rst_n = 1'b0;
        drive(z);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic add_vec(input in_t v, input logic st, input logic [1:0] fr, input logic [1:0] ft);
        vec_t e;
        e.vin = v; e.st = st; e.fr = fr; e.ft = ft;
        tbl.push_back(e);
    endtask

    in_t z_in, lu, lu_fl, lu_fwd, br_exld, br_memld, br_wb;

    initial begin
        z_in    = '0;
        // lw $8 in EX, consumer reads $8 as rs.
        lu      = '{1'b1, 5'd8, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 5'd8, 1'b1, 1'b1,
                    5'd0, 1'b0, 1'b0, 5'd0, 1'b0};
        lu_fl   = lu;  lu_fl.fl = 1'b1;
        lu_fwd  = lu;  lu_fwd.memrd = 5'd8; lu_fwd.memrw = 1'b1;
        br_exld = '{1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1,
                    5'd0, 1'b0, 1'b0, 5'd0, 1'b0};
        br_memld = '{1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0,
                     5'd9, 1'b1, 1'b1, 5'd0, 1'b0};
        br_wb   = '{1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0,
                    5'd0, 1'b0, 1'b0, 5'd9, 1'b1};

        // Single-cycle vectors for the LOAD_LAT=0 instance (every stall here is N=1).
        add_vec(z_in, 1'b0, 2'b00, 2'b00);
        add_vec(lu, 1'b1, 2'b00, 2'b00);
        add_vec('{1'b0, 5'd8, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 5'd8, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0}, 1'b0, 2'b00, 2'b00);
        add_vec('{1'b1, 5'd8, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0, 5'd8, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0}, 1'b0, 2'b00, 2'b00);
        add_vec('{1'b1, 5'd7, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 5'd8, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0}, 1'b1, 2'b00, 2'b00);
        add_vec('{1'b1, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0}, 1'b0, 2'b00, 2'b00);
        add_vec('{1'b1, 5'd8, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0}, 1'b0, 2'b00, 2'b00);
        add_vec('{1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0}, 1'b1, 2'b00, 2'b00);
        add_vec(br_memld, 1'b1, 2'b00, 2'b00);
        add_vec('{1'b1, 5'd11, 5'd10, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd10, 1'b1, 1'b0, 5'd10, 1'b1}, 1'b0, 2'b00, 2'b10);
        add_vec('{1'b1, 5'd11, 5'd10, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd10, 1'b1}, 1'b0, 2'b00, 2'b01);
        add_vec('{1'b1, 5'd11, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1}, 1'b0, 2'b00, 2'b00);
        add_vec(lu_fl, 1'b0, 2'b00, 2'b00);
        add_vec('{1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 5'd4, 1'b1}, 1'b0, 2'b10, 2'b01);
        add_vec('{1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd4, 1'b0, 1'b0, 5'd4, 1'b1}, 1'b0, 2'b00, 2'b01);
        add_vec('{1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b1, 5'd0, 1'b0}, 1'b0, 2'b00, 2'b00);

        // Reset state with hazard and forwarding inputs live.
        rst_n = 1'b0;
        drive(lu_fwd);
        @(negedge clk);
        check8("reset_outputs", out_of(0), 8'b1100_0000);
        check16("reset_count", sc0, 16'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            step($sformatf("vec%0d", i), 0, tbl[i].vin, tbl[i].st, 1'b0, tbl[i].fr, tbl[i].ft);
        end
        check16("vec_stall_count", sc0, 16'd4);

        // LOAD_LAT=0 load-use: one stall cycle.
        do_reset();
        step("t1_stall", 0, lu, 1'b1, 1'b0, 2'b00, 2'b00);
        step("t1_release", 0, z_in, 1'b0, 1'b0, 2'b00, 2'b00);
        check16("t1_count", sc0, 16'd1);

        // LOAD_LAT=2 load-use: three stalls, FSM holds regardless of inputs.
        do_reset();
        step("t2_c1", 1, lu, 1'b1, 1'b0, 2'b00, 2'b00);
        step("t2_c2", 1, z_in, 1'b1, 1'b1, 2'b00, 2'b00);
        step("t2_c3", 1, z_in, 1'b1, 1'b1, 2'b00, 2'b00);
        step("t2_c4", 1, z_in, 1'b0, 1'b0, 2'b00, 2'b00);
        check16("t2_count", sc2, 16'd3);

        // Branch behind a load in EX (LOAD_LAT=0): two stalls then forward from MEM/WB.
        do_reset();
        step("t3_c1", 0, br_exld, 1'b1, 1'b0, 2'b00, 2'b00);
        step("t3_c2", 0, br_memld, 1'b1, 1'b1, 2'b00, 2'b00);
        step("t3_c3", 0, br_wb, 1'b0, 1'b0, 2'b01, 2'b00);
        check16("t3_count", sc0, 16'd2);

        // LOAD_LAT=3 load-use cut short by a flush on stall cycle 2.
        do_reset();
        step("t5_c1", 2, lu, 1'b1, 1'b0, 2'b00, 2'b00);
        step("t5_flush", 2, lu_fl, 1'b0, 1'b1, 2'b00, 2'b00);
        step("t5_idle", 2, z_in, 1'b0, 1'b0, 2'b00, 2'b00);
        check16("t5_count", sc3, 16'd1);

        // Asynchronous reset in the middle of a LOAD_LAT=3 stall.
        do_reset();
        step("t6_c1", 2, lu, 1'b1, 1'b0, 2'b00, 2'b00);
        step("t6_c2", 2, z_in, 1'b1, 1'b1, 2'b00, 2'b00);
        drive(lu_fwd);
        #2;
        rst_n = 1'b0;
        #1;
        check8("t6_reset_outputs", out_of(2), 8'b1100_0000);
        @(posedge clk);
        drive(z_in);
        #1;
        rst_n = 1'b1;
        #1;
        check16("t6_count_after_reset", sc3, 16'd0);
        @(posedge clk);
        #1;
        step("t6_idle_after_reset", 2, z_in, 1'b0, 1'b0, 2'b00, 2'b00);

        // Counter saturation on the 2-bit instance.
        do_reset();
        drive(lu);
        repeat (2) @(posedge clk);
        #1;
        check16("sat_count_2", {14'd0, sc_sat}, 16'd2);
        repeat (3) @(posedge clk);
        #1;
        check16("sat_hold", {14'd0, sc_sat}, 16'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
